// File: rtl/dff_ram_8x72_arbiter.sv
// Two-requester round-robin front end for the single-port 8x72 DFF RAM.
// Grants are combinational. Accepted requests are registered onto the RAM port.
// Read tags travel a latency-matched pipeline so data goes back to the issuer.

// Read-return capture for one requester: latches RAM data on its tag slot, pulses valid next cycle.
module dff_ram_8x72_arbiter_rret #(
  parameter int DW = 72
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap,
  input  logic [DW-1:0] ram_rdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // next-state: capture on tag hit, otherwise hold data
  always_comb begin
    rvalid_d = cap;
    rdata_d  = cap ? ram_rdata : rdata_q;
  end

  // capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
endmodule

module dff_ram_8x72_arbiter #(
  parameter int AW     = 3,
  parameter int DW     = 72,
  parameter int RD_LAT = 1   // 1..4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,
  output logic          ram_wr_n,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t req_sel;
  logic any_gnt;
  logic rd_push;

  // 1 = B was granted most recently, so A wins the next tie
  logic last_b_q, last_b_d;

  logic          ram_wr_n_q, ram_wr_n_d;
  logic [AW-1:0] ram_address_q, ram_address_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;

  // Slot 0 covers the issue cycle; slot RD_LAT lines up with valid ram_rdata.
  logic [RD_LAT:0] vld_pipe_q, vld_pipe_d;
  logic [RD_LAT:0] id_pipe_q, id_pipe_d;

  logic [NUM_REQ-1:0]         cap;
  logic [NUM_REQ-1:0]         rvalid;
  logic [NUM_REQ-1:0][DW-1:0] rdata;

  // round-robin grant and request mux
  always_comb begin
    gnt_a   = req_a & (~req_b | last_b_q);
    gnt_b   = req_b & (~req_a | ~last_b_q);
    any_gnt = gnt_a | gnt_b;
    req_sel = gnt_b ? '{we: we_b, addr: addr_b, wdata: wdata_b}
                    : '{we: we_a, addr: addr_a, wdata: wdata_a};
    rd_push = any_gnt & ~req_sel.we;
  end

  // next-state: pointer, RAM issue registers, read-tag shift
  always_comb begin
    last_b_d      = last_b_q;
    ram_wr_n_d    = 1'b1;
    ram_address_d = ram_address_q;
    ram_wdata_d   = ram_wdata_q;
    if (any_gnt) begin
      last_b_d      = gnt_b;
      ram_wr_n_d    = ~req_sel.we;
      ram_address_d = req_sel.addr;
      ram_wdata_d   = req_sel.wdata;
    end
    vld_pipe_d = {vld_pipe_q[RD_LAT-1:0], rd_push};
    id_pipe_d  = {id_pipe_q[RD_LAT-1:0], gnt_b};
  end

  // state registers; reset drops any pending write strobe and in-flight tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q      <= 1'b1;
      ram_wr_n_q    <= 1'b1;
      ram_address_q <= '0;
      ram_wdata_q   <= '0;
      vld_pipe_q    <= '0;
      id_pipe_q     <= '0;
    end else begin
      last_b_q      <= last_b_d;
      ram_wr_n_q    <= ram_wr_n_d;
      ram_address_q <= ram_address_d;
      ram_wdata_q   <= ram_wdata_d;
      vld_pipe_q    <= vld_pipe_d;
      id_pipe_q     <= id_pipe_d;
    end
  end

  // route the mature tag to its requester
  always_comb begin
    cap[0] = vld_pipe_q[RD_LAT] & ~id_pipe_q[RD_LAT];
    cap[1] = vld_pipe_q[RD_LAT] &  id_pipe_q[RD_LAT];
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rret
    dff_ram_8x72_arbiter_rret #(.DW(DW)) u_rret (
      .clk       (clk),
      .rst_n     (rst_n),
      .cap       (cap[g]),
      .ram_rdata (ram_rdata),
      .rvalid    (rvalid[g]),
      .rdata     (rdata[g])
    );
  end

  assign rvalid_a    = rvalid[0];
  assign rdata_a     = rdata[0];
  assign rvalid_b    = rvalid[1];
  assign rdata_b     = rdata[1];
  assign ram_wr_n    = ram_wr_n_q;
  assign ram_address = ram_address_q;
  assign ram_wdata   = ram_wdata_q;
endmodule

// File: tb/tb_dff_ram_8x72_arbiter.sv
// Randomized + directed bench for dff_ram_8x72_arbiter with a 1-cycle RAM model.
// A negedge monitor predicts grants, RAM port values and read returns from a
// reference memory updated in grant order; expected returns live in a queue.
module tb_dff_ram_8x72_arbiter;
  localparam int AW = 3, DW = 72, LAT = 3;

  logic          clk = 0, rst_n = 0;
  logic          req_a = 0, we_a = 0, req_b = 0, we_b = 0;
  logic [AW-1:0] addr_a = 0, addr_b = 0;
  logic [DW-1:0] wdata_a = 0, wdata_b = 0;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, ram_wr_n;
  logic [DW-1:0] rdata_a, rdata_b, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_address;

  dff_ram_8x72_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .ram_wr_n(ram_wr_n), .ram_address(ram_address), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, one cycle latency
  logic [DW-1:0] ram_mem [8];
  logic [DW-1:0] ram_rd_q = '0;
  initial for (int i = 0; i < 8; i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (!ram_wr_n) ram_mem[ram_address] <= ram_wdata;
    ram_rd_q <= ram_mem[ram_address];
  end
  assign ram_rdata = ram_rd_q;

  int errors = 0, checks = 0, cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // ---------------- reference model + monitor ----------------
  typedef struct { int due; bit id; logic [DW-1:0] data; } exp_t;
  exp_t          q[$];
  logic [DW-1:0] ref_mem [8];
  bit            mlast_b = 1, exp_wr_n = 1;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0, last_a = '0, last_b = '0;
  initial for (int i = 0; i < 8; i++) ref_mem[i] = '0;

  initial forever begin
    bit eg_a, eg_b, er_a, er_b, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_d;
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_wr_n", ram_wr_n, 1);
      chk("rst_addr", ram_address, 0);
      chk("rst_rvalid", {rvalid_b, rvalid_a}, 0);
      chk("rst_rdata_a", rdata_a, 0);
      chk("rst_rdata_b", rdata_b, 0);
      q.delete();
      mlast_b = 1; exp_wr_n = 1; exp_addr = '0; exp_wdata = '0;
      last_a = '0; last_b = '0;
    end else begin
      // whoever did not win last time takes a tie
      eg_a = req_a && (!req_b || mlast_b);
      eg_b = req_b && !eg_a;
      chk("gnt_a", gnt_a, eg_a);
      chk("gnt_b", gnt_b, eg_b);
      chk("ram_wr_n", ram_wr_n, exp_wr_n);
      chk("ram_address", ram_address, exp_addr);
      chk("ram_wdata", ram_wdata, exp_wdata);
      er_a = 0; er_b = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (e.id) begin er_b = 1; last_b = e.data; end
        else      begin er_a = 1; last_a = e.data; end
      end
      chk("rvalid_a", rvalid_a, er_a);
      chk("rvalid_b", rvalid_b, er_b);
      chk("rdata_a", rdata_a, last_a);
      chk("rdata_b", rdata_b, last_b);
      if (eg_a || eg_b) begin
        s_we   = eg_b ? we_b : we_a;
        s_addr = eg_b ? addr_b : addr_a;
        s_d    = eg_b ? wdata_b : wdata_a;
        if (s_we) ref_mem[s_addr] = s_d;
        else      q.push_back('{cyc + LAT, eg_b, ref_mem[s_addr]});
        exp_wr_n = !s_we; exp_addr = s_addr; exp_wdata = s_d;
        mlast_b = eg_b;
      end else begin
        exp_wr_n = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; holds the request until granted, returns at posedge+1 after grant.
  task automatic issue(bit id, bit we, logic [AW-1:0] addr, logic [DW-1:0] d, bit jitter);
    if (id) begin req_b = 1; we_b = we; addr_b = addr; wdata_b = d; end
    else    begin req_a = 1; we_a = we; addr_a = addr; wdata_a = d; end
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (id ? gnt_b : gnt_a) break;
      if (i > 40) begin
        checks++; errors++;
        $display("FAIL grant_timeout req %0d: no grant after %0d cycles", id, i);
        break;
      end
      @(posedge clk); #1;
      // fields may legally change before the grant
      if (jitter && $urandom_range(0, 2) == 0) begin
        if (id) begin addr_b = AW'($urandom()); wdata_b = rand72(); end
        else    begin addr_a = AW'($urandom()); wdata_a = rand72(); end
      end
    end
    @(posedge clk); #1;
    if (id) req_b = 0; else req_a = 0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(int n);
    rst_n = 0;
    idle(n);
    rst_n = 1;
  endtask

  task automatic rand_stream(bit id, int n);
    for (int k = 0; k < n; k++) begin
      idle($urandom_range(0, 2));
      issue(id, $urandom_range(0, 1), AW'($urandom()), rand72(), 1);
    end
  endtask

  initial begin
    #1;
    idle(2);
    rst_n = 1;
    idle(3);

    // A-only sweep: writes 1..8, then reads back
    for (int i = 0; i < 8; i++) issue(0, 1, AW'(i), DW'(i + 1), 0);
    for (int i = 0; i < 8; i++) issue(0, 0, AW'(i), '0, 0);
    idle(5);

    // contention from reset: alternating grants
    do_reset(2);
    fork
      for (int i = 0; i < 6; i++) issue(0, 0, 3'd2, '0, 0);
      for (int i = 0; i < 6; i++) issue(1, 0, 3'd5, '0, 0);
    join
    idle(5);

    // write then read of the same address from the other requester
    fork
      issue(0, 1, 3'd4, 72'hFF_0000_0000_0000_00AA, 0);
      begin idle(1); issue(1, 0, 3'd4, '0, 0); end
    join
    idle(5);

    // pointer holds across idle cycles
    issue(1, 0, 3'd1, '0, 0);
    idle(3);
    fork
      begin issue(0, 0, 3'd3, '0, 0); issue(0, 0, 3'd6, '0, 0); end
      begin issue(1, 0, 3'd0, '0, 0); issue(1, 0, 3'd7, '0, 0); end
    join
    idle(5);

    // reset one cycle after a read grant; the returned data must never show up
    issue(0, 0, 3'd3, '0, 0);
    do_reset(2);
    idle(4);
    // reset during a write strobe (value already stored, so memory stays consistent)
    issue(0, 1, 3'd7, DW'(8), 0);
    do_reset(2);
    fork
      issue(0, 0, 3'd7, '0, 0);
      issue(1, 0, 3'd2, '0, 0);
    join
    idle(5);

    // randomized traffic from both sides
    fork
      rand_stream(0, 80);
      rand_stream(1, 80);
    join
    idle(8);

    chk("drain_queue", DW'(q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dff_ram_8x72_arbiter.md
Name: dff_ram_8x72_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port dff_ram_8x72 (8 words x 72 bits, active-low write strobe).
- Accepts one read or write per cycle from requester A or B and drives the RAM's clk-domain interface (wr_n, address, wdata).
- Returns read data to the requester that issued the read, tagged through a latency-matched pipeline.

Parameters:
- AW, 3, RAM address width (8 words).
- DW, 72, RAM data width.
- RD_LAT, 1, RAM read latency in cycles from address presented (wr_n=1) to valid ram_rdata; legal 1..4.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  requester A request; held with we_a/addr_a/wdata_a stable until gnt_a.
- we_a  input  1  1 = write, 0 = read.
- addr_a  input  AW  word address.
- wdata_a  input  DW  write data.
- gnt_a  output  1  combinational accept for A in the current cycle.
- rvalid_a  output  1  one-cycle pulse, rdata_a valid.
- rdata_a  output  DW  registered read data for A.
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as A for requester B.
- ram_wr_n  output  1  to RAM wr_n; 0 = write this cycle.
- ram_address  output  AW  to RAM address.
- ram_wdata  output  DW  to RAM wdata.
- ram_rdata  input  DW  from RAM rdata.

Behaviour:
- Reset (async, rst_n=0): ram_wr_n=1, ram_address=0, ram_wdata=0, rvalid_a/b=0, rdata_a/b=0, read-tag pipeline cleared, round-robin pointer = "B last granted" (A wins first tie).
- Arbitration (combinational, cycle N): only one req high -> that requester granted. Both high -> grant the one not granted most recently. At most one of gnt_a/gnt_b high. No req -> no grant.
- Pointer updates on the clk edge ending a grant cycle; unchanged when idle.
- Issue (registered): on the edge ending cycle N, the granted request loads ram_address, ram_wdata and ram_wr_n (=~we). ram_wr_n is low for exactly cycle N+1 for a write.
- No grant in N -> ram_wr_n=1 in N+1; ram_address and ram_wdata hold their last values.
- Read return: a read granted in cycle N pushes tag {valid, id} into a pipeline of depth 1+RD_LAT. In cycle N+1+RD_LAT, ram_rdata is captured into rdata_<id>. rvalid_<id> pulses high in cycle N+2+RD_LAT (total latency 2+RD_LAT from grant; 3 at default).
- rdata_x holds its value between pulses.
- Back-to-back reads (one per cycle, any requester mix) are fully pipelined; rvalid order equals grant order.
- Writes produce no rvalid.
- Ordering: RAM accesses occur strictly in grant order. A read granted the cycle after a write to the same address returns the new data.
- Throughput: one access per cycle sustained. With both requesters continuously requesting, grants alternate A,B,A,B.
- Requester may deassert req only after gnt. Changing fields before gnt is legal; the value in the grant cycle is used.
- Reset mid-operation: in-flight read tags are discarded, no rvalid fires after reset release for pre-reset reads, and an in-flight write strobe is forced high immediately.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> ram_wr_n=1, ram_address=0, rvalid_a/b=0, rdata=0; no grant with req low.
- A-only sweep: A writes addr 0..7 with data 1..8 (one per cycle) -> gnt_a every cycle, ram_wr_n low cycles 1..8 after first grant with matching address/wdata. A then reads 0..7 -> rvalid_a pulses 3 cycles after each grant with rdata_a = 1..8.
- Contention: A and B both request reads every cycle from reset -> grants A,B,A,B. rvalid_a/rvalid_b alternate with data from their own addresses (A addr 2 -> 3, B addr 5 -> 6).
- Write-then-read hazard: A writes addr 4 = 72'hFF_0000_0000_0000_00AA in cycle N, B reads addr 4 in cycle N+1 -> rdata_b = 72'hFF_0000_0000_0000_00AA, rvalid_a never pulses.
- Fairness/pointer hold: B granted alone, 3 idle cycles, then both request -> A granted first; next tie -> B.
- Reset mid-read: A read granted, rst_n pulsed low at grant+1 -> no rvalid_a afterward, ram_wr_n=1, first post-reset tie goes to A.
